// File: rtl/matmul_pkg.sv
// Shared widths, FSM encoding and row-major address helper for the matrix-multiply reader.
package matmul_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 6;
  localparam int unsigned ACC_W = 19;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  function automatic logic [AW-1:0] idx(input logic [AW-1:0] row, input logic [AW-1:0] col);
    return AW'(row * AW'(N) + col);
  endfunction

endpackage

// File: rtl/matmul_reader_if.sv
// Operand-read, result-write and control signals of the matrix-multiply reader.
interface matmul_reader_if;
  import matmul_pkg::*;

  logic                    start;
  logic [AW-1:0]           a_addr1, a_addr2, b_addr1, b_addr2;
  logic signed [DW-1:0]    a_dout1, a_dout2, b_dout1, b_dout2;
  logic [AW-1:0]           c_addr;
  logic signed [ACC_W-1:0] c_data;
  logic                    c_we;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, a_dout1, a_dout2, b_dout1, b_dout2,
    output a_addr1, a_addr2, b_addr1, b_addr2, c_addr, c_data, c_we, busy, done
  );

  modport slave (
    output start, a_dout1, a_dout2, b_dout1, b_dout2,
    input  a_addr1, a_addr2, b_addr1, b_addr2, c_addr, c_data, c_we, busy, done
  );
endinterface

// File: rtl/matmul_reader_mac2.sv
// Dual signed multiply, each product sign-extended to the accumulator width, then summed.
module mac2
  import matmul_pkg::*;
(
  input  logic signed [DW-1:0]    a1_i,
  input  logic signed [DW-1:0]    a2_i,
  input  logic signed [DW-1:0]    b1_i,
  input  logic signed [DW-1:0]    b2_i,
  output logic signed [ACC_W-1:0] sum_o
);

  logic signed [2*DW-1:0] p1, p2;

  always_comb begin
    p1    = a1_i * b1_i;
    p2    = a2_i * b2_i;
    sum_o = {{(ACC_W-2*DW){p1[2*DW-1]}}, p1} + {{(ACC_W-2*DW){p2[2*DW-1]}}, p2};
  end

endmodule

// File: rtl/matmul_reader.sv
// Sequencer computing C = A x B, two k-steps per cycle from dual-port operand RAMs.
module matmul_reader
  import matmul_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  matmul_reader_if.master mm_if
);

  localparam logic [AW-1:0] K_LAST = AW'(N - 2);
  localparam logic [AW-1:0] IJ_LAST = AW'(N - 1);

  state_e                  state_q, state_d;
  logic [AW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, pair_sum;
  logic                    pv_q, pv_d;
  logic [AW-1:0]           a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
  logic [AW-1:0]           c_addr_q, c_addr_d;
  logic signed [ACC_W-1:0] c_data_q, c_data_d;
  logic                    c_we_q, c_we_d, done_q, done_d;

  mac2 u_mac2 (
    .a1_i  (mm_if.a_dout1),
    .a2_i  (mm_if.a_dout2),
    .b1_i  (mm_if.b_dout1),
    .b2_i  (mm_if.b_dout2),
    .sum_o (pair_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      pv_q     <= 1'b0;
      a1_q     <= '0;
      a2_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
      c_we_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      pv_q     <= pv_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
      c_we_q   <= c_we_d;
      done_q   <= done_d;
    end
  end

  // Write strobe/data are registered on the DRAIN edge so they appear during WRITE,
  // with c_data already including the final pair accumulated on that same edge.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    pv_d     = pv_q;
    acc_d    = pv_q ? acc_q + pair_sum : acc_q;
    a1_d     = a1_q;
    a2_d     = a2_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    c_we_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mm_if.start) begin
          state_d = READ;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          pv_d    = 1'b0;
        end
      end
      READ: begin
        a1_d = idx(i_q, k_q);
        a2_d = idx(i_q, k_q + AW'(1));
        b1_d = idx(k_q, j_q);
        b2_d = idx(k_q + AW'(1), j_q);
        pv_d = 1'b1;
        k_d  = k_q + AW'(2);
        if (k_q == K_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        pv_d     = 1'b0;
        state_d  = WRITE;
        c_we_d   = 1'b1;
        c_addr_d = idx(i_q, j_q);
        c_data_d = acc_d;
      end
      WRITE: begin
        acc_d = '0;
        k_d   = '0;
        if (j_q < IJ_LAST) begin
          j_d     = j_q + AW'(1);
          state_d = READ;
        end else if (i_q < IJ_LAST) begin
          j_d     = '0;
          i_d     = i_q + AW'(1);
          state_d = READ;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses are live during READ and otherwise hold the last issued values.
  always_comb begin
    mm_if.a_addr1 = (state_q == READ) ? idx(i_q, k_q)              : a1_q;
    mm_if.a_addr2 = (state_q == READ) ? idx(i_q, k_q + AW'(1))     : a2_q;
    mm_if.b_addr1 = (state_q == READ) ? idx(k_q, j_q)              : b1_q;
    mm_if.b_addr2 = (state_q == READ) ? idx(k_q + AW'(1), j_q)     : b2_q;
    mm_if.c_addr  = c_addr_q;
    mm_if.c_data  = c_data_q;
    mm_if.c_we    = c_we_q;
    mm_if.done    = done_q;
    mm_if.busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_matmul_reader.sv
// Directed and random checks of matmul_reader against a plain-arithmetic matrix product.
module tb_matmul_reader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic signed [7:0] amem [64];
  logic signed [7:0] bmem [64];
  int                expc [64];

  matmul_reader_if mm ();

  matmul_reader dut (
    .clk   (clk),
    .reset (reset),
    .mm_if (mm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mm.a_dout1 <= amem[mm.a_addr1];
    mm.a_dout2 <= amem[mm.a_addr2];
    mm.b_dout1 <= bmem[mm.b_addr1];
    mm.b_dout2 <= bmem[mm.b_addr2];
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void golden();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(amem[r*8+k]) * int'(bmem[k*8+c]);
        expc[r*8+c] = s;
      end
  endfunction

  // Called right after the edge that accepted start; watches one full multiply.
  task automatic run_monitor(input string tag, input bit release_start, input bit stray,
                             input int reset_at);
    int nwr = 0;
    int busy_low = 0;
    int done_cyc = -1;
    for (int cyc = 1; cyc <= 500; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && release_start) mm.start = 1'b0;
      if (stray && cyc == 50) mm.start = 1'b1;
      if (stray && cyc == 51) mm.start = 1'b0;
      if (!mm.busy) busy_low++;
      if (mm.c_we) begin
        if (nwr < 64) begin
          check({tag, " c_addr"}, longint'(mm.c_addr), longint'(nwr));
          check({tag, " c_data"}, longint'(mm.c_data), longint'(expc[nwr]));
          check({tag, " write_cycle"}, longint'(cyc), longint'(6 + 6*nwr));
        end
        nwr++;
        if (nwr == reset_at) begin
          int late_we = 0;
          int late_done = 0;
          reset = 1'b1;
          @(negedge clk);
          check({tag, " rst busy"}, longint'(mm.busy), 0);
          check({tag, " rst c_we"}, longint'(mm.c_we), 0);
          check({tag, " rst done"}, longint'(mm.done), 0);
          reset = 1'b0;
          for (int w = 0; w < 450; w++) begin
            @(negedge clk);
            if (mm.c_we) late_we++;
            if (mm.done) late_done++;
          end
          check({tag, " post-reset c_we"}, longint'(late_we), 0);
          check({tag, " post-reset done"}, longint'(late_done), 0);
          return;
        end
      end
      if (mm.done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, " done_cycle"}, longint'(done_cyc), 385);
    check({tag, " writes"}, longint'(nwr), 64);
    check({tag, " busy_low"}, longint'(busy_low), 0);
  endtask

  task automatic start_run(input string tag, input bit stray);
    @(negedge clk);
    mm.start = 1'b1;
    @(posedge clk);
    run_monitor(tag, 1'b1, stray, 0);
    @(negedge clk);
    check({tag, " done_pulse_len"}, longint'(mm.done), 0);
    check({tag, " idle_busy"}, longint'(mm.busy), 0);
  endtask

  initial begin
    mm.start = 1'b0;
    for (int n = 0; n < 64; n++) begin
      amem[n] = '0;
      bmem[n] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset busy", longint'(mm.busy), 0);
    check("reset done", longint'(mm.done), 0);
    check("reset c_we", longint'(mm.c_we), 0);
    check("reset c_addr", longint'(mm.c_addr), 0);
    check("reset c_data", longint'(mm.c_data), 0);
    check("reset a_addr1", longint'(mm.a_addr1), 0);
    check("reset b_addr2", longint'(mm.b_addr2), 0);
    reset = 1'b0;

    // Identity A: C must equal B exactly.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        amem[r*8+c] = (r == c) ? 8'sd1 : 8'sd0;
        bmem[r*8+c] = 8'(r*8 + c - 32);
        expc[r*8+c] = r*8 + c - 32;
      end
    start_run("identity", 1'b0);

    for (int n = 0; n < 64; n++) begin
      amem[n] = -8'sd128;
      bmem[n] = -8'sd128;
      expc[n] = 131072;
    end
    start_run("neg_extreme", 1'b0);

    for (int n = 0; n < 64; n++) begin
      amem[n] = 8'sd127;
      bmem[n] = -8'sd128;
      expc[n] = -130048;
    end
    start_run("mixed_sign", 1'b0);

    for (int n = 0; n < 64; n++) begin
      amem[n] = 8'($urandom);
      bmem[n] = 8'($urandom);
    end
    golden();
    start_run("random", 1'b0);

    start_run("stray_start", 1'b1);

    @(negedge clk);
    mm.start = 1'b1;
    @(posedge clk);
    run_monitor("reset_mid", 1'b1, 1'b0, 10);
    start_run("after_reset", 1'b0);

    for (int n = 0; n < 64; n++) begin
      amem[n] = 8'($urandom);
      bmem[n] = 8'($urandom);
    end
    golden();
    @(negedge clk);
    mm.start = 1'b1;
    @(posedge clk);
    run_monitor("held_run1", 1'b0, 1'b0, 0);
    @(negedge clk);
    check("held gap busy", longint'(mm.busy), 0);
    check("held gap done", longint'(mm.done), 0);
    @(posedge clk);
    run_monitor("held_run2", 1'b1, 1'b0, 0);
    @(negedge clk);
    check("held_run2 idle_busy", longint'(mm.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
